// File: rtl/isa_sequencer.sv
// ============================================================================
// Module   : isa_sequencer
// Brief    : Runs a loadable program of 20-bit instructions into the ISA
//            datapath and streams each settled 32-bit result out (valid/ready).
// Revision : 1.0
// ============================================================================
`default_nettype none

module isa_sequencer #(
    parameter int DEPTH  = 16,
    parameter int SETTLE = 2,
    parameter int AW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          prog_we,
    input  logic [AW-1:0] prog_addr,
    input  logic [19:0]   prog_data,
    input  logic          start,
    input  logic [AW:0]   len,
    output logic          busy,
    output logic          done,
    output logic [19:0]   instruccion,
    input  logic [31:0]   salida,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [31:0]   res_data,
    output logic [AW-1:0] res_idx
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_OUT    = 2'd2;

    localparam int              CW         = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]   c_CNT_LAST = CW'(SETTLE - 1);
    localparam logic [AW:0]     c_DEPTH    = (AW + 1)'(DEPTH);

    logic [1:0]    r_state;
    logic [1:0]    w_next;
    logic [AW-1:0] r_pc;
    logic [CW-1:0] r_cnt;
    logic [AW:0]   r_len;
    logic          r_busy;
    logic          r_done;
    logic [19:0]   r_instr;
    logic          r_res_valid;
    logic [31:0]   r_res_data;
    logic [AW-1:0] r_res_idx;
    logic [19:0]   r_mem [DEPTH];

    logic          w_accept;
    logic          w_empty;
    logic          w_capture;
    logic          w_hs;
    logic          w_last;
    logic [AW-1:0] w_pc_nxt;
    logic [AW:0]   w_len_clamp;

    // Program store has no reset; contents survive across runs and resets.
    always_ff @(posedge clk) begin
        if (prog_we && !r_busy) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_accept)  w_next = S_SETTLE;
            S_SETTLE: if (w_capture) w_next = S_OUT;
            S_OUT:    if (w_hs)      w_next = w_last ? S_IDLE : S_SETTLE;
            default:                 w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_accept    = (r_state == S_IDLE) && start && (len != '0);
        w_empty     = (r_state == S_IDLE) && start && (len == '0);
        w_capture   = (r_state == S_SETTLE) && (r_cnt == c_CNT_LAST);
        w_hs        = (r_state == S_OUT) && res_ready;
        w_last      = ({1'b0, r_pc} == (r_len - (AW + 1)'(1)));
        w_pc_nxt    = r_pc + AW'(1);
        w_len_clamp = (len > c_DEPTH) ? c_DEPTH : len;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= '0;
            r_cnt       <= '0;
            r_len       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_instr     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_idx   <= '0;
        end else begin
            r_done <= w_empty || (w_hs && w_last);
            if (w_accept) begin
                r_len   <= w_len_clamp;
                r_pc    <= '0;
                r_instr <= r_mem[0];
                r_cnt   <= '0;
                r_busy  <= 1'b1;
            end
            if (r_state == S_SETTLE) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_capture) begin
                r_res_data  <= salida;
                r_res_idx   <= r_pc;
                r_res_valid <= 1'b1;
            end
            if (w_hs) begin
                r_res_valid <= 1'b0;
                if (w_last) begin
                    r_busy <= 1'b0;
                end else begin
                    r_pc    <= w_pc_nxt;
                    r_instr <= r_mem[w_pc_nxt];
                    r_cnt   <= '0;
                end
            end
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign instruccion = r_instr;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_idx     = r_res_idx;

endmodule

`default_nettype wire

// File: tb/tb_isa_sequencer.sv
// ============================================================================
// Module   : tb_isa_sequencer
// Brief    : Directed self-checking bench for isa_sequencer with an ISA stub.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_isa_sequencer;

    localparam int DEPTH  = 16;
    localparam int SETTLE = 2;
    localparam int AW     = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          prog_we;
    logic [AW-1:0] prog_addr;
    logic [19:0]   prog_data;
    logic          start;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [19:0]   instruccion;
    logic [31:0]   salida;
    logic          res_valid;
    logic          res_ready;
    logic [31:0]   res_data;
    logic [AW-1:0] res_idx;

    int checks   = 0;
    int failures = 0;

    logic [19:0] prog [DEPTH];

    isa_sequencer #(.DEPTH(DEPTH), .SETTLE(SETTLE), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .start      (start),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .instruccion(instruccion),
        .salida     (salida),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_idx    (res_idx)
    );

    // ISA stand-in: result is a fixed tag over the issued instruction.
    assign salida = {12'hABC, instruccion};

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [AW:0] n);
        start = 1'b1;
        len   = n;
        tick();
        start = 1'b0;
    endtask

    // Consumes results until done, optionally stalling one index.
    task automatic collect(input int n, input int stall_idx, input int stall_n);
        int got = 0;
        int stalled = 0;
        int cyc = 0;
        logic seen_done = 1'b0;
        while (!seen_done && cyc < 300) begin
            check("busy_done_excl", {31'd0, busy & done}, 32'd0);
            if (done) begin
                seen_done = 1'b1;
            end else if (res_valid) begin
                if (got < DEPTH) begin
                    check("res_data", res_data, {12'hABC, prog[got]});
                    check("instr_hold", {12'd0, instruccion}, {12'd0, prog[got]});
                end
                check("res_idx", {28'd0, res_idx}, got);
                if (int'(res_idx) == stall_idx && stalled < stall_n) begin
                    res_ready = 1'b0;
                    stalled++;
                end else begin
                    res_ready = 1'b1;
                    got++;
                end
            end else begin
                res_ready = 1'b1;
            end
            if (!seen_done) begin
                tick();
                cyc++;
            end
        end
        check("done_seen", {31'd0, seen_done}, 32'd1);
        check("result_count", got, n);
        if (stall_idx >= 0) check("stall_cycles", stalled, stall_n);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        tick();
        check("done_one_cycle", {31'd0, done}, 32'd0);
        res_ready = 1'b1;
    endtask

    initial begin
        int hold_cyc;
        logic exp_v;
        rst       = 1'b1;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        start     = 1'b0;
        len       = '0;
        res_ready = 1'b1;

        prog[0] = 20'h11C87;
        prog[1] = 20'h09D81;
        prog[2] = 20'h0100F;
        prog[3] = 20'h18C51;
        prog[4] = 20'h38DD3;
        for (int i = 5; i < DEPTH; i++) prog[i] = 20'h5A000 | 20'(i);

        tick();
        tick();
        check("rst_busy",      {31'd0, busy},       32'd0);
        check("rst_done",      {31'd0, done},       32'd0);
        check("rst_res_valid", {31'd0, res_valid},  32'd0);
        check("rst_res_data",  res_data,            32'd0);
        check("rst_res_idx",   {28'd0, res_idx},    32'd0);
        check("rst_instr",     {12'd0, instruccion}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < DEPTH; i++) begin
            prog_we   = 1'b1;
            prog_addr = AW'(i);
            prog_data = prog[i];
            tick();
        end
        prog_we = 1'b0;

        // Cycle-exact 5-instruction run; len changed after acceptance.
        start_run(5'd5);
        len = '0;
        check("e0_busy",  {31'd0, busy}, 32'd1);
        check("e0_instr", {12'd0, instruccion}, {12'd0, prog[0]});
        for (int c = 1; c <= 16; c++) begin
            tick();
            exp_v = (c >= 2) && (c <= 14) && ((c - 2) % 3 == 0);
            check("t_valid", {31'd0, res_valid}, {31'd0, exp_v});
            check("t_done",  {31'd0, done}, (c == 15) ? 32'd1 : 32'd0);
            check("t_busy",  {31'd0, busy}, (c < 15) ? 32'd1 : 32'd0);
            if (exp_v) begin
                check("t_data", res_data, {12'hABC, prog[(c - 2) / 3]});
                check("t_idx",  {28'd0, res_idx}, (c - 2) / 3);
            end
        end

        // Backpressure on result 2.
        start_run(5'd5);
        collect(5, 2, 4);

        // Empty run: done pulse only.
        start_run(5'd0);
        check("len0_done",  {31'd0, done},      32'd1);
        check("len0_busy",  {31'd0, busy},      32'd0);
        check("len0_valid", {31'd0, res_valid}, 32'd0);
        tick();
        check("len0_done_drop", {31'd0, done},      32'd0);
        check("len0_busy2",     {31'd0, busy},      32'd0);
        check("len0_valid2",    {31'd0, res_valid}, 32'd0);

        // Over-long run clamps to DEPTH.
        start_run(5'd20);
        collect(DEPTH, -1, 0);

        // Program write and start pulse while busy are dropped.
        start_run(5'd5);
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = 20'hFFFFF;
        start     = 1'b1;
        len       = 5'd3;
        tick();
        prog_we = 1'b0;
        start   = 1'b0;
        collect(5, -1, 0);
        start_run(5'd5);
        collect(5, -1, 0);

        // Reset while result 1 is pending.
        start_run(5'd5);
        hold_cyc = 0;
        while (!(res_valid && res_idx == 4'd1) && hold_cyc < 50) begin
            res_ready = 1'b1;
            tick();
            hold_cyc++;
        end
        check("reach_out1", {31'd0, res_valid && res_idx == 4'd1}, 32'd1);
        res_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        res_ready = 1'b1;
        check("abort_busy",  {31'd0, busy},        32'd0);
        check("abort_done",  {31'd0, done},        32'd0);
        check("abort_valid", {31'd0, res_valid},   32'd0);
        check("abort_data",  res_data,             32'd0);
        check("abort_idx",   {28'd0, res_idx},     32'd0);
        check("abort_instr", {12'd0, instruccion}, 32'd0);
        tick();
        check("abort_no_done", {31'd0, done},  32'd0);
        check("abort_idle",    {31'd0, busy},  32'd0);
        start_run(5'd5);
        collect(5, -1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
